// File: rtl/muxn_pipe_rr.sv
// N-channel, W-bit selector with a registered valid/ready output stage.
// Selection is either directed by sel (mode 0) or round-robin over valid channels (mode 1).
module muxn_pipe_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int SELW  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        out_chan,
    output logic                   sel_err
);

    // Handshake: a word moves on a channel when in_valid[i] && in_ready[i];
    // the output word leaves when out_valid && out_ready. in_ready never looks
    // at another channel's in_valid beyond the grant decision.

    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   grant;
    logic             load_en;
    logic             xfer;
    logic             sel_oor;
    logic [WIDTH-1:0] gnt_data;
    logic [SELW-1:0]  gnt_chan;

    assign load_en  = !out_valid || out_ready;
    assign sel_oor  = (int'(sel) >= NCH);
    assign in_ready = grant & {NCH{load_en}};
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (i == int'(sel) && in_valid[i]) begin
                    grant[i] = 1'b1;
                end
            end
        end else begin
            // Search starts one past the last granted channel and wraps.
            for (int k = 1; k <= NCH; k++) begin
                idx = (int'(ptr) + k) % NCH;
                for (int i = 0; i < NCH; i++) begin
                    if (!found && i == idx && in_valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    // Only the granted lane is muxed, so unused channel data never reaches out_data.
    always_comb begin
        gnt_data = '0;
        gnt_chan = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_chan = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            sel_err   <= 1'b0;
            ptr       <= SELW'(NCH - 1);
        end else begin
            sel_err <= !mode && sel_oor;
            if (load_en) begin
                if (xfer) begin
                    out_data  <= gnt_data;
                    out_chan  <= gnt_chan;
                    out_valid <= 1'b1;
                    ptr       <= gnt_chan;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_muxn_pipe_rr.sv
// Directed bench for muxn_pipe_rr (NCH=3, WIDTH=8) with hand-computed expectations.
module tb_muxn_pipe_rr;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 reset;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_chan;
    logic                 sel_err;

    int n_checks;
    int n_fail;

    muxn_pipe_rr #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .sel_err   (sel_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check_eq({tag, "_valid"}, out_valid, v);
        check_eq({tag, "_data"}, out_data, d);
        check_eq({tag, "_chan"}, out_chan, c);
    endtask

    logic [1:0] seq_full [6];
    logic [1:0] seq_ac   [4];
    logic [7:0] chan_val [3];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_data   = {8'h33, 8'h22, 8'h11};
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        seq_full  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        seq_ac    = '{2'd0, 2'd2, 2'd0, 2'd2};
        chan_val  = '{8'h11, 8'h22, 8'h33};

        // 1. reset state
        do_reset(2);
        check_out("rst", 1'b0, 8'h00, 2'd0);
        check_eq("rst_sel_err", sel_err, 1'b0);
        check_eq("rst_in_ready", in_ready, 3'b000);
        tick();
        check_eq("idle_valid", out_valid, 1'b0);

        // 2. directed select, back-to-back without bubble
        mode = 1'b0; sel = 2'd1; in_valid = 3'b111;
        settle();
        check_eq("dir1_in_ready", in_ready, 3'b010);
        tick();
        check_out("dir1", 1'b1, 8'h22, 2'd1);
        sel = 2'd2;
        settle();
        check_eq("dir2_in_ready", in_ready, 3'b100);
        tick();
        check_out("dir2", 1'b1, 8'h33, 2'd2);

        // directed select of a non-valid channel gets no grant
        sel = 2'd0; in_valid = 3'b110;
        settle();
        check_eq("dir_novalid_in_ready", in_ready, 3'b000);

        // 3. out-of-range select
        sel = 2'd3; in_valid = 3'b111;
        settle();
        check_eq("oor_in_ready", in_ready, 3'b000);
        tick();
        check_eq("oor_sel_err", sel_err, 1'b1);
        check_eq("oor_valid", out_valid, 1'b0);
        sel = 2'd0; in_valid = 3'b000;
        tick();
        check_eq("oor_sel_err_clear", sel_err, 1'b0);
        check_eq("oor_data_held", out_data, 8'h33);

        // 4. round-robin fairness
        do_reset(1);
        mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out($sformatf("rr_full%0d", i), 1'b1, chan_val[seq_full[i]], seq_full[i]);
        end
        in_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("rr_ac%0d", i), 1'b1, chan_val[seq_ac[i]], seq_ac[i]);
        end

        // 5. backpressure
        do_reset(1);
        mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        tick();
        check_out("bp_load", 1'b1, 8'h11, 2'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("bp_in_ready%0d", i), in_ready, 3'b000);
            tick();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 8'h11, 2'd0);
        end
        out_ready = 1'b1;
        settle();
        check_eq("bp_release_in_ready", in_ready, 3'b010);
        tick();
        check_out("bp_release", 1'b1, 8'h22, 2'd1);

        // 6. reset mid-operation restarts the round-robin at channel 0
        do_reset(1);
        mode = 1'b1; in_valid = 3'b111;
        tick();
        check_eq("mid_g0", out_chan, 2'd0);
        tick();
        check_eq("mid_g1", out_chan, 2'd1);
        reset = 1'b1;
        tick();
        check_out("mid_rst", 1'b0, 8'h00, 2'd0);
        reset = 1'b0;
        tick();
        check_out("mid_after", 1'b1, 8'h11, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
